// File: rtl/io_reg_pkg.sv
// Shared constants and types for the IO register pipe: depth limits and valid-counter width.
package io_reg_pkg;

    localparam int unsigned IO_REG_MAX_DEPTH = 4;
    localparam int unsigned IO_REG_CNT_W     = 3;

    // Legal pipeline depths are 1..IO_REG_MAX_DEPTH; checked at elaboration in the stage chain.
    typedef int unsigned io_reg_depth_t;

endpackage

// File: rtl/io_reg_stage_chain.sv
// Enabled shift chain of DEPTH registers plus a saturating fill counter that raises vld
// once the last stage holds a post-reset sample.
module io_reg_stage_chain
    import io_reg_pkg::*;
#(
    parameter int unsigned   W     = 8,
    parameter io_reg_depth_t DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         vld
);

    if (DEPTH == 0 || DEPTH > IO_REG_MAX_DEPTH) begin : g_bad_depth
        $error("io_reg_stage_chain: DEPTH=%0d outside legal range 1..%0d", DEPTH, IO_REG_MAX_DEPTH);
    end

    localparam logic [IO_REG_CNT_W-1:0] CNT_FULL = IO_REG_CNT_W'(DEPTH);

    logic [DEPTH-1:0][W-1:0]    stage_d, stage_q;
    logic [IO_REG_CNT_W-1:0]    cnt_d, cnt_q;
    logic                       vld_d, vld_q;

    // en=1 shifts the whole chain one place and counts one fill step; en=0 freezes
    // data and counter alike. vld is sticky until reset once the chain has filled.
    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (en) begin
            stage_d[0] = d;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        vld_d = (cnt_d == CNT_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
        end
    end

    assign q   = stage_q[DEPTH-1];
    assign vld = vld_q;

endmodule

// File: rtl/io_reg_pipe.sv
// Bidirectional IO register cell: pipelined A2F->IQZ and OQI->F2A paths with per-lane bypass
// and constant-drive outputs.
module io_reg_pipe
    import io_reg_pkg::*;
#(
    parameter int unsigned   A2F_W     = 8,
    parameter int unsigned   F2A_W     = 18,
    parameter int unsigned   DEF_W     = 4,
    parameter io_reg_depth_t IN_DEPTH  = 1,
    parameter io_reg_depth_t OUT_DEPTH = 1
) (
    input  logic             IQC,
    input  logic             QRT_N,
    input  logic [A2F_W-1:0] ISEL,
    input  logic [A2F_W-1:0] FIXHOLD,
    input  logic             IQE,
    input  logic [A2F_W-1:0] A2F,
    output logic [A2F_W-1:0] IQZ,
    output logic             IN_VLD,
    input  logic [F2A_W-1:0] OSEL,
    input  logic             OQE,
    input  logic [F2A_W-1:0] OQI,
    output logic [F2A_W-1:0] F2A,
    output logic             OUT_VLD,
    input  logic [DEF_W-1:0] DSEL,
    output logic [DEF_W-1:0] F2A_DEF
);

    logic [A2F_W-1:0] in_last;
    logic [F2A_W-1:0] out_last;

    io_reg_stage_chain #(.W(A2F_W), .DEPTH(IN_DEPTH)) u_in_chain (
        .clk   (IQC),
        .rst_n (QRT_N),
        .en    (IQE),
        .d     (A2F),
        .q     (in_last),
        .vld   (IN_VLD)
    );

    io_reg_stage_chain #(.W(F2A_W), .DEPTH(OUT_DEPTH)) u_out_chain (
        .clk   (IQC),
        .rst_n (QRT_N),
        .en    (OQE),
        .d     (OQI),
        .q     (out_last),
        .vld   (OUT_VLD)
    );

    // Bypassed lanes follow the pad/fabric input directly, even during reset.
    assign IQZ     = (ISEL & A2F) | (~ISEL & in_last);
    assign F2A     = (OSEL & OQI) | (~OSEL & out_last);
    assign F2A_DEF = DSEL;

    // FIXHOLD only carries a per-lane hold buffer for the timing model.
    logic unused_fixhold;
    assign unused_fixhold = ^FIXHOLD;

endmodule

// File: tb/tb_io_reg_pipe.sv
// Self-checking bench for io_reg_pipe (IN_DEPTH=3, OUT_DEPTH=2): directed scenarios plus random
// traffic compared against a sample-history model of each path.
module tb_io_reg_pipe;

    localparam int A2F_W     = 8;
    localparam int F2A_W     = 18;
    localparam int DEF_W     = 4;
    localparam int IN_DEPTH  = 3;
    localparam int OUT_DEPTH = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             qrt_n;
    logic [A2F_W-1:0] isel, fixhold, a2f, iqz;
    logic             iqe, in_vld;
    logic [F2A_W-1:0] osel, oqi, f2a;
    logic             oqe, out_vld;
    logic [DEF_W-1:0] dsel, f2a_def;

    io_reg_pipe #(
        .A2F_W(A2F_W), .F2A_W(F2A_W), .DEF_W(DEF_W),
        .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .IQC(clk), .QRT_N(qrt_n), .ISEL(isel), .FIXHOLD(fixhold), .IQE(iqe),
        .A2F(a2f), .IQZ(iqz), .IN_VLD(in_vld), .OSEL(osel), .OQE(oqe),
        .OQI(oqi), .F2A(f2a), .OUT_VLD(out_vld), .DSEL(dsel), .F2A_DEF(f2a_def)
    );

    // ---------------- scoreboard ----------------
    // Each queue holds the samples accepted since reset, newest first. A registered lane
    // shows the sample accepted DEPTH enabled edges ago, or 0 if the pipe has not filled.
    logic [A2F_W-1:0] in_exp_q[$];
    logic [F2A_W-1:0] out_exp_q[$];
    int               in_accepted;
    int               out_accepted;
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!qrt_n) begin
            in_exp_q.delete();
            out_exp_q.delete();
            in_accepted  = 0;
            out_accepted = 0;
        end else begin
            if (iqe) begin
                in_exp_q.push_front(a2f);
                in_accepted++;
                while (in_exp_q.size() > IN_DEPTH) void'(in_exp_q.pop_back());
            end
            if (oqe) begin
                out_exp_q.push_front(oqi);
                out_accepted++;
                while (out_exp_q.size() > OUT_DEPTH) void'(out_exp_q.pop_back());
            end
        end
    endtask

    task automatic compare_all();
        logic [A2F_W-1:0] in_old, exp_iqz;
        logic [F2A_W-1:0] out_old, exp_f2a;
        in_old  = (in_accepted >= IN_DEPTH) ? in_exp_q[IN_DEPTH-1] : '0;
        out_old = (out_accepted >= OUT_DEPTH) ? out_exp_q[OUT_DEPTH-1] : '0;
        for (int i = 0; i < A2F_W; i++) exp_iqz[i] = isel[i] ? a2f[i] : in_old[i];
        for (int j = 0; j < F2A_W; j++) exp_f2a[j] = osel[j] ? oqi[j] : out_old[j];
        check_eq("iqz",     32'(iqz),     32'(exp_iqz));
        check_eq("f2a",     32'(f2a),     32'(exp_f2a));
        check_eq("in_vld",  32'(in_vld),  32'(in_accepted >= IN_DEPTH));
        check_eq("out_vld", 32'(out_vld), 32'(out_accepted >= OUT_DEPTH));
        check_eq("f2a_def", 32'(f2a_def), 32'(dsel));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive_idle();
        qrt_n = 1'b1; isel = '0; osel = '0; fixhold = '0; iqe = 1'b0; oqe = 1'b0;
        a2f = '0; oqi = '0; dsel = '0;
    endtask

    task automatic do_reset();
        qrt_n = 1'b0;
        step();
        qrt_n = 1'b1;
    endtask

    task automatic drive_random(input int rst_pct, input int bypass_pct);
        qrt_n   = ($urandom_range(99) < rst_pct) ? 1'b0 : 1'b1;
        iqe     = 1'($urandom_range(1));
        oqe     = 1'($urandom_range(1));
        a2f     = A2F_W'($urandom);
        oqi     = F2A_W'($urandom);
        dsel    = DEF_W'($urandom);
        fixhold = A2F_W'($urandom);
        isel    = ($urandom_range(99) < bypass_pct) ? A2F_W'($urandom) : '0;
        osel    = ($urandom_range(99) < bypass_pct) ? F2A_W'($urandom) : '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [A2F_W-1:0] seq_a[$];
        logic [A2F_W-1:0] seq_b[$];
        drive_idle();
        in_accepted  = 0;
        out_accepted = 0;
        #2;

        // 1: reset with registered lanes and all-ones pad data
        a2f = 8'hFF; oqi = '1; iqe = 1'b1; oqe = 1'b1;
        do_reset();
        check_eq("rst_iqz",     32'(iqz),     32'h00);
        check_eq("rst_f2a",     32'(f2a),     32'h0);
        check_eq("rst_in_vld",  32'(in_vld),  32'h0);
        check_eq("rst_out_vld", 32'(out_vld), 32'h0);

        // 2: latency, A5 accepted at edge n appears after edge n+2
        iqe = 1'b1; a2f = 8'hA5;
        step();
        check_eq("lat_vld_n",   32'(in_vld), 32'h0);
        step();
        check_eq("lat_vld_n1",  32'(in_vld), 32'h0);
        step();
        check_eq("lat_iqz_n2",  32'(iqz),    32'hA5);
        check_eq("lat_vld_n2",  32'(in_vld), 32'h1);

        // 3: output stall mid-pipe
        drive_idle();
        do_reset();
        oqe = 1'b1; oqi = 18'h3_0F0F;
        step();
        oqi = 18'h0_1234; oqe = 1'b0;
        for (int s = 0; s < 4; s++) begin
            step();
            check_eq("stall_hold", 32'(f2a), 32'h0);
        end
        oqe = 1'b1;
        step();
        check_eq("stall_emerge", 32'(f2a),     32'h3_0F0F);
        check_eq("stall_vld",    32'(out_vld), 32'h1);

        // 4: bypass mix against an empty pipe
        drive_idle();
        do_reset();
        isel = 8'h0F; a2f = 8'h5A; osel = '1; oqi = 18'h2_A5C3;
        #1;
        check_eq("byp_iqz", 32'(iqz), 32'h0A);
        check_eq("byp_f2a", 32'(f2a), 32'h2_A5C3);

        // 5: reset mid-stream, then refill takes IN_DEPTH edges
        drive_idle();
        iqe = 1'b1;
        for (int s = 0; s < IN_DEPTH + 1; s++) begin
            a2f = A2F_W'($urandom);
            step();
        end
        check_eq("mid_full_vld", 32'(in_vld), 32'h1);
        do_reset();
        check_eq("mid_rst_vld", 32'(in_vld), 32'h0);
        check_eq("mid_rst_iqz", 32'(iqz),    32'h0);
        for (int s = 0; s < IN_DEPTH; s++) begin
            a2f = 8'h30 + 8'(s);
            step();
            check_eq("refill_vld", 32'(in_vld), 32'(s == IN_DEPTH - 1));
        end
        check_eq("refill_iqz", 32'(iqz), 32'h30);

        // 6: constant drives and FIXHOLD transparency
        drive_idle();
        dsel = 4'b1010;
        #1;
        check_eq("def_const", 32'(f2a_def), 32'hA);
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            iqe = 1'b1;
            for (int v = 0; v < 256; v++) begin
                fixhold = (pass == 0) ? 8'h00 : 8'(v);
                a2f     = 8'(v * 37 + 11);
                step();
                if (pass == 0) seq_a.push_back(iqz);
                else           seq_b.push_back(iqz);
            end
        end
        for (int v = 0; v < 256; v += 17) begin
            check_eq("fixhold_seq", 32'(seq_b[v]), 32'(seq_a[v]));
        end

        // random traffic with occasional resets and bypass
        drive_idle();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            drive_random(3, 25);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
